// File: rtl/vram_arbiter.sv
// Purpose : N-client VRAM arbiter. Fixed priority for client 0 (optional) over round-robin;
//           runs one timed VRAM cycle per grant on registered, active-low strobes.
// Latency : request sampled at edge t -> ack pulse in the cycle after edge t+ACCESS_CYCLES;
//           back-to-back throughput is one access per ACCESS_CYCLES+2 clocks.
// Backpr. : level req is held by the client until its ack; losers simply keep waiting.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   req/wr               per-client request level and direction (1 = write)
//   addr/be/wr_data      flattened per-client payload, client i at [i*W +: W]
//   ack                  one-hot, one-cycle completion pulse
//   rd_data              read data, valid in the ack cycle and held until the next read
//   _vram_en/_rd/_wr/_be active-low VRAM strobes
//   vram_addr            VRAM address
//   vram_data_out/_oe    write data and pad drive enable
//   vram_data_in         read data from pad
module vram_arbiter #(
   parameter int NUM_CLIENTS      = 3,
   parameter int ADDR_WIDTH       = 17,
   parameter int DATA_WIDTH       = 16,
   parameter int ACCESS_CYCLES    = 2,
   parameter int PRIORITY_CLIENT0 = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_CLIENTS-1:0]              req,
   input  logic [NUM_CLIENTS-1:0]              wr,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]   addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH/8-1:0] be,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]   wr_data,
   output logic [NUM_CLIENTS-1:0]              ack,
   output logic [DATA_WIDTH-1:0]               rd_data,
   output logic                                _vram_en,
   output logic                                _vram_rd,
   output logic                                _vram_wr,
   output logic [DATA_WIDTH/8-1:0]             _vram_be,
   output logic [ADDR_WIDTH-1:0]               vram_addr,
   output logic [DATA_WIDTH-1:0]               vram_data_out,
   output logic                                vram_data_oe,
   input  logic [DATA_WIDTH-1:0]               vram_data_in
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(NUM_CLIENTS);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       gnt_q, gnt_d;
   logic                   dir_wr_q, dir_wr_d;
   logic [NUM_CLIENTS-1:0] ack_q, ack_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                   en_n_q, en_n_d;
   logic                   rd_n_q, rd_n_d;
   logic                   wr_n_q, wr_n_d;
   logic [BE_W-1:0]        be_n_q, be_n_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  dout_q, dout_d;
   logic                   oe_q, oe_d;

   // ------------------------------------------------------------------
   // Winner selection. The request vector is rotated so that the pointer
   // position lands at bit 0; the first set bit is then the offset from
   // the pointer, and the offset is added back modulo NUM_CLIENTS.
   // ------------------------------------------------------------------
   logic [2*NUM_CLIENTS-1:0] req_dbl;
   logic [NUM_CLIENTS-1:0]   req_rot;
   logic [IDX_W-1:0]         rr_off;
   logic                     rr_found;
   logic [IDX_W:0]           rr_sum;
   logic [IDX_W-1:0]         win_idx;
   logic                     any_req;

   always_comb begin
      req_dbl  = {req, req} >> ptr_q;
      req_rot  = req_dbl[NUM_CLIENTS-1:0];
      rr_off   = '0;
      rr_found = 1'b0;
      for (int d = 0; d < NUM_CLIENTS; d++) begin
         if (!rr_found && req_rot[d]) begin
            rr_found = 1'b1;
            rr_off   = IDX_W'(d);
         end
      end
      rr_sum = {1'b0, ptr_q} + {1'b0, rr_off};
      if (rr_sum >= (IDX_W+1)'(NUM_CLIENTS)) begin
         rr_sum = rr_sum - (IDX_W+1)'(NUM_CLIENTS);
      end
      win_idx = IDX_W'(rr_sum);
      // Display refresh pre-empts the rotation when enabled.
      if ((PRIORITY_CLIENT0 != 0) && req[0]) begin
         win_idx = '0;
      end
      any_req = |req;
   end

   // Payload of the winning client.
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BE_W-1:0]       sel_be;
   logic [DATA_WIDTH-1:0] sel_wdat;
   logic                  sel_wr;

   always_comb begin
      sel_addr = '0;
      sel_be   = '0;
      sel_wdat = '0;
      sel_wr   = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_be   = be[i*BE_W +: BE_W];
            sel_wdat = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_wr   = wr[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Access sequencer: next-state and registered-output logic.
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      dir_wr_d  = dir_wr_q;
      ack_d     = ack_q;
      rd_data_d = rd_data_q;
      en_n_d    = en_n_q;
      rd_n_d    = rd_n_q;
      wr_n_d    = wr_n_q;
      be_n_d    = be_n_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      oe_d      = oe_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_ACCESS;
               gnt_d    = win_idx;
               dir_wr_d = sel_wr;
               addr_d   = sel_addr;
               dout_d   = sel_wdat;
               // Strobes, byte lanes and pad drive all go active on the
               // grant edge so data is valid with the first strobe cycle.
               en_n_d   = 1'b0;
               rd_n_d   = sel_wr;
               wr_n_d   = ~sel_wr;
               be_n_d   = ~sel_be;
               oe_d     = sel_wr;
               cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
            end
         end

         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (!dir_wr_q) begin
                  rd_data_d = vram_data_in;
               end
               ack_d   = NUM_CLIENTS'(1) << gnt_q;
               en_n_d  = 1'b1;
               rd_n_d  = 1'b1;
               wr_n_d  = 1'b1;
               be_n_d  = '1;
               oe_d    = 1'b0;
               ptr_d   = (gnt_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gnt_q + 1'b1;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_ACK: begin
            // Turnaround: requests are not looked at here, which gives the
            // acked client a clock to drop its req before the next grant.
            ack_d   = '0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         dir_wr_q  <= 1'b0;
         ack_q     <= '0;
         rd_data_q <= '0;
         en_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         be_n_q    <= '1;
         addr_q    <= '0;
         dout_q    <= '0;
         oe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         dir_wr_q  <= dir_wr_d;
         ack_q     <= ack_d;
         rd_data_q <= rd_data_d;
         en_n_q    <= en_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         be_n_q    <= be_n_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         oe_q      <= oe_d;
      end
   end

   assign ack           = ack_q;
   assign rd_data       = rd_data_q;
   assign _vram_en      = en_n_q;
   assign _vram_rd      = rd_n_q;
   assign _vram_wr      = wr_n_q;
   assign _vram_be      = be_n_q;
   assign vram_addr     = addr_q;
   assign vram_data_out = dout_q;
   assign vram_data_oe  = oe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Purpose : exercises two arbiter instances (client-0 priority on / off) against a
//           transaction-timeline model, plus directed scenarios with literal expectations.
// Latency : checks every negedge; inputs change only on negedges.
module tb_vram_arbiter;

   localparam int N  = 3;
   localparam int AW = 17;
   localparam int DW = 16;
   localparam int BW = DW / 8;
   localparam int AC = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // index 0: PRIORITY_CLIENT0=1, index 1: PRIORITY_CLIENT0=0
   logic [N-1:0]    req   [2];
   logic [N-1:0]    wr    [2];
   logic [N*AW-1:0] addr  [2];
   logic [N*BW-1:0] be    [2];
   logic [N*DW-1:0] wdat  [2];
   logic [DW-1:0]   vdin  [2];
   logic [N-1:0]    ack   [2];
   logic [DW-1:0]   rdd   [2];
   logic            en_n  [2];
   logic            rd_n  [2];
   logic            wr_n  [2];
   logic [BW-1:0]   be_n  [2];
   logic [AW-1:0]   vaddr [2];
   logic [DW-1:0]   vdout [2];
   logic            oe    [2];

   vram_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .ACCESS_CYCLES(AC), .PRIORITY_CLIENT0(1)) u_dut0 (
      .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .be(be[0]),
      .wr_data(wdat[0]), .ack(ack[0]), .rd_data(rdd[0]), ._vram_en(en_n[0]),
      ._vram_rd(rd_n[0]), ._vram_wr(wr_n[0]), ._vram_be(be_n[0]), .vram_addr(vaddr[0]),
      .vram_data_out(vdout[0]), .vram_data_oe(oe[0]), .vram_data_in(vdin[0]));

   vram_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .ACCESS_CYCLES(AC), .PRIORITY_CLIENT0(0)) u_dut1 (
      .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .be(be[1]),
      .wr_data(wdat[1]), .ack(ack[1]), .rd_data(rdd[1]), ._vram_en(en_n[1]),
      ._vram_rd(rd_n[1]), ._vram_wr(wr_n[1]), ._vram_be(be_n[1]), .vram_addr(vaddr[1]),
      .vram_data_out(vdout[1]), .vram_data_oe(oe[1]), .vram_data_in(vdin[1]));

   // ---------------- transaction-timeline model ----------------
   // m_j = clocks elapsed since the grant edge; strobes active for j < AC,
   // ack at j == AC, model free again one clock later.
   bit            m_busy [2];
   int            m_j    [2];
   int            m_g    [2];
   int            m_ptr  [2];
   bit            m_wr   [2];
   logic [BW-1:0] m_be   [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_wdat [2];
   logic [DW-1:0] m_rd   [2];

   function automatic int pick(input int k);
      if (k == 0 && req[k][0]) return 0;
      for (int d = 0; d < N; d++) begin
         if (req[k][(m_ptr[k] + d) % N]) return (m_ptr[k] + d) % N;
      end
      return 0;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_busy[k] <= 1'b0;
            m_j[k]    <= 0;
            m_g[k]    <= 0;
            m_ptr[k]  <= 0;
            m_wr[k]   <= 1'b0;
            m_be[k]   <= '0;
            m_addr[k] <= '0;
            m_wdat[k] <= '0;
            m_rd[k]   <= '0;
         end else if (m_busy[k]) begin
            if (m_j[k] + 1 == AC) begin
               if (!m_wr[k]) m_rd[k] <= vdin[k];
               m_ptr[k] <= (m_g[k] + 1) % N;
            end
            if (m_j[k] + 1 == AC + 1) m_busy[k] <= 1'b0;
            m_j[k] <= m_j[k] + 1;
         end else if (req[k] != '0) begin
            m_busy[k] <= 1'b1;
            m_j[k]    <= 0;
            m_g[k]    <= pick(k);
            m_wr[k]   <= wr[k][pick(k)];
            m_be[k]   <= be[k][pick(k)*BW +: BW];
            m_addr[k] <= addr[k][pick(k)*AW +: AW];
            m_wdat[k] <= wdat[k][pick(k)*DW +: DW];
         end
      end
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all(input int k);
      logic          act;
      logic [N-1:0]  eack;
      logic [BW-1:0] ebe;
      act  = m_busy[k] && (m_j[k] < AC);
      eack = (m_busy[k] && m_j[k] == AC) ? (N'(1) << m_g[k]) : '0;
      ebe  = act ? ~m_be[k] : '1;
      chk($sformatf("d%0d ack", k),     32'(ack[k]),   32'(eack));
      chk($sformatf("d%0d en_n", k),    32'(en_n[k]),  32'(!act));
      chk($sformatf("d%0d rd_n", k),    32'(rd_n[k]),  32'(act ? m_wr[k] : 1'b1));
      chk($sformatf("d%0d wr_n", k),    32'(wr_n[k]),  32'(act ? !m_wr[k] : 1'b1));
      chk($sformatf("d%0d oe", k),      32'(oe[k]),    32'(act && m_wr[k]));
      chk($sformatf("d%0d be_n", k),    32'(be_n[k]),  32'(ebe));
      chk($sformatf("d%0d addr", k),    32'(vaddr[k]), 32'(m_addr[k]));
      chk($sformatf("d%0d dout", k),    32'(vdout[k]), 32'(m_wdat[k]));
      chk($sformatf("d%0d rd_data", k), 32'(rdd[k]),   32'(m_rd[k]));
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all(0);
      compare_all(1);
   endtask

   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic rand_client(input int k, input int i);
      wr[k][i]              = 1'($urandom_range(0, 1));
      addr[k][i*AW +: AW]   = AW'($urandom);
      be[k][i*BW +: BW]     = BW'($urandom);
      wdat[k][i*DW +: DW]   = DW'($urandom);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_en, n_ack, n_wr, n_oe, bad_cnt, c_en, c_ack;
      logic [N-1:0] ackv;
      int q0[$], q1[$], t1q[$];
      int exp0 [7];
      int exp1 [4];
      bit added0;
      logic [N-1:0] first_ack [2];

      exp0 = '{1, 2, 1, 2, 0, 1, 2};
      exp1 = '{0, 1, 2, 0};
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = '0; wr[k] = '0; addr[k] = '0; be[k] = '0; wdat[k] = '0; vdin[k] = '0;
      end
      repeat (2) tick();
      chk("reset en_n", 32'(en_n[0]), 32'd1);
      chk("reset be_n", 32'(be_n[0]), 32'h3);
      chk("reset oe/ack", 32'({oe[0], ack[0]}), 32'd0);
      reset = 1'b0;

      // Client 1 read of 0x1ABCD; address changed once the access is under way.
      addr[0][1*AW +: AW] = 17'h1ABCD;
      be[0][1*BW +: BW]   = 2'b11;
      wr[0][1]            = 1'b0;
      vdin[0]             = 16'hBEEF;
      req[0][1]           = 1'b1;
      n_en = 0; n_ack = 0; bad_cnt = 0; c_en = -1; c_ack = -1; ackv = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (!en_n[0]) begin
            n_en++;
            if (c_en < 0) c_en = c;
            if (vaddr[0] != 17'h1ABCD || rd_n[0]) bad_cnt++;
            addr[0][1*AW +: AW] = 17'h00000;
         end
         if (ack[0] != '0) begin
            n_ack++; ackv = ack[0]; c_ack = c;
            req[0] = req[0] & ~ack[0];
         end
      end
      chk("t1 strobe cycles", 32'(n_en), 32'd2);
      chk("t1 addr held", 32'(bad_cnt), 32'd0);
      chk("t1 ack value", 32'(ackv), 32'h2);
      chk("t1 ack cycles", 32'(n_ack), 32'd1);
      chk("t1 ack latency", 32'(c_ack - c_en), 32'd2);
      chk("t1 rd_data", 32'(rdd[0]), 32'hBEEF);

      // Client 2 write of 0x1234 to 0x00010, low byte only.
      addr[0][2*AW +: AW] = 17'h00010;
      be[0][2*BW +: BW]   = 2'b01;
      wdat[0][2*DW +: DW] = 16'h1234;
      wr[0][2]            = 1'b1;
      vdin[0]             = 16'h5555;
      req[0][2]           = 1'b1;
      n_wr = 0; n_oe = 0; bad_cnt = 0; n_ack = 0; ackv = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (!wr_n[0]) begin
            n_wr++;
            if (be_n[0] != 2'b10 || vdout[0] != 16'h1234 || !oe[0]) bad_cnt++;
         end
         if (oe[0]) n_oe++;
         if (ack[0] != '0) begin
            n_ack++; ackv = ack[0];
            req[0] = req[0] & ~ack[0];
         end
      end
      chk("t2 wr strobe cycles", 32'(n_wr), 32'd2);
      chk("t2 oe cycles", 32'(n_oe), 32'd2);
      chk("t2 lanes/data", 32'(bad_cnt), 32'd0);
      chk("t2 ack", 32'({n_ack[3:0], ackv}), 32'({4'd1, 3'b100}));
      chk("t2 rd_data kept", 32'(rdd[0]), 32'hBEEF);

      // Continuous requests: 1,2 on the priority instance (0 joins later),
      // all three on the pure round-robin instance.
      req[0] = 3'b110;
      req[1] = 3'b111;
      added0 = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (ack[0] != '0 && q0.size() < 7) q0.push_back(idx_of(ack[0]));
         if (ack[0][0]) req[0][0] = 1'b0;
         if (q0.size() == 4 && !added0) begin
            req[0][0] = 1'b1;
            added0 = 1'b1;
         end
         if (ack[1] != '0 && q1.size() < 4) begin
            q1.push_back(idx_of(ack[1]));
            t1q.push_back(c);
         end
      end
      chk("t3 d0 grants", 32'(q0.size()), 32'd7);
      for (int i = 0; i < q0.size(); i++) chk($sformatf("t3 d0 grant%0d", i), 32'(q0[i]), 32'(exp0[i]));
      chk("t3 d1 grants", 32'(q1.size()), 32'd4);
      for (int i = 0; i < q1.size(); i++) chk($sformatf("t3 d1 grant%0d", i), 32'(q1[i]), 32'(exp1[i]));
      for (int i = 0; i + 1 < t1q.size(); i++) chk($sformatf("t3 d1 spacing%0d", i), 32'(t1q[i+1] - t1q[i]), 32'd4);
      req[0] = '0;
      req[1] = '0;
      repeat (8) tick();

      // Park both pointers at 2, then abort a client-2 access with reset.
      for (int k = 0; k < 2; k++) begin wr[k] = '0; req[k] = 3'b010; end
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int k = 0; k < 2; k++) req[k] = req[k] & ~ack[k];
      end
      for (int k = 0; k < 2; k++) begin wr[k][2] = 1'b1; req[k] = 3'b110; end
      for (int c = 0; c < 10 && en_n[0]; c++) tick();
      chk("t4 access started", 32'(en_n[0]), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t4 d%0d strobes async", k), 32'({en_n[k], rd_n[k], wr_n[k]}), 32'h7);
         chk($sformatf("t4 d%0d oe/ack async", k), 32'({oe[k], ack[k]}), 32'd0);
      end
      tick();
      reset = 1'b0;
      first_ack[0] = '0;
      first_ack[1] = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            if (ack[k] != '0 && first_ack[k] == '0) first_ack[k] = ack[k];
            req[k] = req[k] & ~ack[k];
         end
      end
      chk("t4 d0 first after reset", 32'(first_ack[0]), 32'h2);
      chk("t4 d1 first after reset", 32'(first_ack[1]), 32'h2);
      repeat (4) tick();

      // Random traffic, including payload changes while requests are pending
      // or in service, zero byte enables and occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            vdin[k] = DW'($urandom);
            for (int i = 0; i < N; i++) begin
               if (req[k][i] && ack[k][i]) begin
                  req[k][i] = 1'b0;
               end else if (!req[k][i] && $urandom_range(0, 2) == 0) begin
                  rand_client(k, i);
                  req[k][i] = 1'b1;
               end else if ($urandom_range(0, 7) == 0) begin
                  rand_client(k, i);
               end
            end
         end
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b1;
            #2 reset = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Parametrised N-client VRAM arbiter; replaces the combinational MPU/GPU VRAM mux in the ChronoCube top level.
- Each client (GPU line fetch, MPU, future blitter/sprite engines) raises a level request with address, byte enables, direction and write data.
- The arbiter grants one client at a time under fixed-priority-plus-round-robin policy and runs a timed VRAM cycle with active-low strobes.
- It returns read data with a one-cycle acknowledge.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8)
- ADDR_WIDTH, 17, VRAM address width
- DATA_WIDTH, 16, VRAM data width (multiple of 8)
- ACCESS_CYCLES, 2, clocks strobes stay asserted per access (1..15)
- PRIORITY_CLIENT0, 1, 1 = client 0 (display refresh) always wins; 0 = pure round-robin

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_CLIENTS  per-client access request, level, held until ack
- wr  in  NUM_CLIENTS  per-client direction: 1 = write, 0 = read
- addr  in  NUM_CLIENTS*ADDR_WIDTH  flattened addresses; client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- be  in  NUM_CLIENTS*DATA_WIDTH/8  flattened byte enables, active high
- wr_data  in  NUM_CLIENTS*DATA_WIDTH  flattened write data
- ack  out  NUM_CLIENTS  one-hot, one-cycle completion pulse
- rd_data  out  DATA_WIDTH  read data; valid in the ack cycle, held until next read completes
- _vram_en  out  1  VRAM enable, active low
- _vram_rd  out  1  VRAM read strobe, active low
- _vram_wr  out  1  VRAM write strobe, active low
- _vram_be  out  DATA_WIDTH/8  VRAM byte enables, active low
- vram_addr  out  ADDR_WIDTH  VRAM address
- vram_data_out  out  DATA_WIDTH  write data to pad
- vram_data_oe  out  1  pad drive enable; high only during write access
- vram_data_in  in  DATA_WIDTH  read data from pad

Behaviour:
- All outputs are registered; no combinational path from req to VRAM pins.
- Reset values:
  - state IDLE
  - _vram_en, _vram_rd, _vram_wr = 1
  - _vram_be all 1
  - vram_addr, vram_data_out, rd_data = 0
  - vram_data_oe = 0, ack = 0
  - round-robin pointer = 0, counter = 0
- Reset mid-access drops all strobes and oe asynchronously; no ack is issued; the aborted client must re-request.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - On an edge with any req bit high, select winner g, latch addr/be/wr_data/wr of g into output registers, and go to ACCESS.
  - In the same edge, assert _vram_en=0, _vram_rd=wr[g], _vram_wr=~wr[g], _vram_be=~be[g], and vram_data_oe=wr[g].
  - Load counter = ACCESS_CYCLES-1.
- ACCESS:
  - Strobes are stable for exactly ACCESS_CYCLES clocks.
  - Counter decrements each edge.
  - On the edge where counter==0:
    - capture rd_data <= vram_data_in if read (rd_data unchanged on write);
    - set ack[g]=1;
    - deassert all strobes and oe;
    - advance pointer to (g+1) mod NUM_CLIENTS;
    - go to ACK.
- ACK:
  - One turnaround cycle; ack[g] high; req is ignored.
  - Next edge: ack=0, go to IDLE.
- Timing: request sampled at edge t gives ack high during the cycle after edge t+ACCESS_CYCLES. Back-to-back throughput is one access per ACCESS_CYCLES+2 clocks.
- Clients must hold req, addr, be, wr and wr_data stable until ack is seen, and drop req on the edge ending the ack cycle. Inputs are sampled only in IDLE, so later changes do not affect an access in progress.
- Arbitration:
  - If PRIORITY_CLIENT0=1 and req[0]=1, g=0.
  - Otherwise g = first requesting index found searching upward from pointer with wrap.
  - With PRIORITY_CLIENT0=1, client 0 grants still advance the pointer to 1.
- Pointer wraps from NUM_CLIENTS-1 to 0.
- be all zero: the access still runs with _vram_be all 1 and acks normally.
- Write data is driven on vram_data_out from the IDLE→ACCESS edge, so data and oe are valid with the first strobe cycle.

Test Plan:
- Reset released, client 1 reads addr 0x1ABCD with ACCESS_CYCLES=2 and vram_data_in=0xBEEF → _vram_en/_vram_rd low for exactly 2 clocks, vram_addr=0x1ABCD, ack=3'b010 for 1 cycle, rd_data=0xBEEF.
- Client 2 writes 0x1234 to 0x00010 with be=2'b01 → _vram_wr low 2 cycles, _vram_be=2'b10, vram_data_oe=1 only during those cycles, rd_data unchanged, ack[2] pulse.
- Clients 1 and 2 request continuously with PRIORITY_CLIENT0=1 → grants alternate 1,2,1,2; adding client 0 makes it win the next IDLE, after which grant order resumes 1 then 2.
- PRIORITY_CLIENT0=0 and all three clients requesting → grant order 0,1,2,0, one grant per 4 clocks.
- Reset asserted in the second ACCESS cycle → strobes high and oe low asynchronously in the same cycle, no ack; after release a held req is re-serviced from pointer 0.
- Client changes addr mid-access → vram_addr keeps the value latched at grant.
